// File: rtl/queue_ctrl_pkg.sv
// Shared definitions for the circular-buffer queue controller: occupancy-FSM encodings, default address width.
// Latency: n/a (constants only); backpressure: n/a.
package queue_ctrl_pkg;

    localparam int         QC_AW_DEFAULT = 3;

    localparam logic [1:0] Q_EMPTY   = 2'd0;
    localparam logic [1:0] Q_PARTIAL = 2'd1;
    localparam logic [1:0] Q_FULL    = 2'd2;

endpackage

// File: rtl/updown_count.sv
// Up/down occupancy counter from a chain of half adder/subtractor slices, async reset, sync clear.
// Latency: Q updates one edge after Enable; backpressure: none, Enable is sampled every cycle.
module updown_count #(
    parameter int W = 4
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         Clear,
    input  logic         Enable,
    input  logic         Direction,
    output logic [W-1:0] Q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic [W-1:0] ci;

    assign ci[0] = 1'b1;

    // Each slice toggles on carry-in; the carry ripples on a 1 counting up, on a 0 counting down.
    for (genvar i = 0; i < W; i++) begin : g_has
        assign q_d[i] = q_q[i] ^ ci[i];
        if (i < W - 1) begin : g_carry
            assign ci[i+1] = ci[i] & (Direction ? ~q_q[i] : q_q[i]);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            q_q <= '0;
        end else if (Clear) begin
            q_q <= '0;
        end else if (Enable) begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/queue_ctrl.sv
// Pointer/occupancy controller for a 2^AW-entry circular buffer: acceptance, pointers, FSM, sticky errors.
// Latency: strobes combinational, flags/Count/pointers one edge later; backpressure: push refused when full unless popping.
module queue_ctrl
    import queue_ctrl_pkg::*;
#(
    parameter int AW = QC_AW_DEFAULT
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Clear,
    input  logic          Push,
    input  logic          Pop,
    output logic          Wr_En,
    output logic [AW-1:0] Wr_Addr,
    output logic          Rd_En,
    output logic [AW-1:0] Rd_Addr,
    output logic [AW:0]   Count,
    output logic          Full,
    output logic          Empty,
    output logic          Overflow,
    output logic          Underflow
);

    localparam int          CW       = AW + 1;
    localparam int          DEPTH    = 2 ** AW;
    localparam logic [AW:0] CNT_LAST = CW'(DEPTH - 1);
    localparam logic [AW:0] CNT_ONE  = CW'(1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]    state_q, state_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          push_ok;
    logic          pop_ok;
    logic [AW:0]   count;

    // A push into a full queue is still taken when a pop frees the slot in the same cycle.
    assign pop_ok  = ~Clear & Pop & ~empty_q;
    assign push_ok = ~Clear & Push & (~full_q | pop_ok);

    updown_count #(
        .W (CW)
    ) u_count (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Clear     (Clear),
        .Enable    (push_ok ^ pop_ok),
        .Direction (pop_ok),
        .Q         (count)
    );

    always_comb begin
        state_d = state_q;
        if (Clear) begin
            state_d = Q_EMPTY;
        end else begin
            case (state_q)
                Q_EMPTY: begin
                    if (push_ok && !pop_ok) begin
                        state_d = (DEPTH == 1) ? Q_FULL : Q_PARTIAL;
                    end
                end
                Q_PARTIAL: begin
                    if (push_ok && !pop_ok && count == CNT_LAST) begin
                        state_d = Q_FULL;
                    end else if (pop_ok && !push_ok && count == CNT_ONE) begin
                        state_d = Q_EMPTY;
                    end
                end
                Q_FULL: begin
                    if (pop_ok && !push_ok) begin
                        state_d = (DEPTH == 1) ? Q_EMPTY : Q_PARTIAL;
                    end
                end
                default: state_d = Q_EMPTY;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = Clear ? '0 : wr_ptr_q + AW'(push_ok);
        rd_ptr_d = Clear ? '0 : rd_ptr_q + AW'(pop_ok);
        full_d   = (state_d == Q_FULL);
        empty_d  = (state_d == Q_EMPTY);
        ovf_d    = ~Clear & (ovf_q | (Push & full_q & ~Pop));
        udf_d    = ~Clear & (udf_q | (Pop & empty_q));
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= Q_EMPTY;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign Wr_En     = push_ok;
    assign Rd_En     = pop_ok;
    assign Wr_Addr   = wr_ptr_q;
    assign Rd_Addr   = rd_ptr_q;
    assign Count     = count;
    assign Full      = full_q;
    assign Empty     = empty_q;
    assign Overflow  = ovf_q;
    assign Underflow = udf_q;

endmodule

// File: tb/tb_queue_ctrl.sv
// Directed bench for queue_ctrl: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_queue_ctrl;

    logic       Clk;
    logic       Rst_n;
    logic       Clear;
    logic       Push;
    logic       Pop;
    logic       Wr_En;
    logic [2:0] Wr_Addr;
    logic       Rd_En;
    logic [2:0] Rd_Addr;
    logic [3:0] Count;
    logic       Full;
    logic       Empty;
    logic       Overflow;
    logic       Underflow;

    queue_ctrl #(.AW(3)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Clear     (Clear),
        .Push      (Push),
        .Pop       (Pop),
        .Wr_En     (Wr_En),
        .Wr_Addr   (Wr_Addr),
        .Rd_En     (Rd_En),
        .Rd_Addr   (Rd_Addr),
        .Count     (Count),
        .Full      (Full),
        .Empty     (Empty),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    typedef struct {
        int   id;
        logic we;
        logic re;
        int   wa;
        int   ra;
        int   cnt;
        logic f;
        logic e;
        logic ov;
        logic un;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   vec_id = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors, required completion", vec_id);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int id, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s vec%0d: got %0d required %0d", nm, id, got, want);
        end
    endtask

    // Drive one cycle at the falling edge; expectations describe what is visible before the next rising edge.
    task automatic cyc(input logic rst, input logic ps, input logic pp, input logic cl,
                       input logic we, input logic re, input int wa, input int ra, input int cnt,
                       input logic f, input logic e, input logic ov, input logic un);
        exp_t x;
        @(negedge Clk);
        Rst_n = ~rst;
        Push  = ps;
        Pop   = pp;
        Clear = cl;
        x.id = vec_id; x.we = we; x.re = re; x.wa = wa; x.ra = ra; x.cnt = cnt;
        x.f = f; x.e = e; x.ov = ov; x.un = un;
        exp_q.push_back(x);
        vec_id++;
    endtask

    initial begin
        forever begin
            @(negedge Clk);
            #2;
            while (exp_q.size() > 0) begin
                logic [2:0] diff;
                mon_e = exp_q.pop_front();
                chk("wr_en",     mon_e.id, int'(Wr_En),     int'(mon_e.we));
                chk("rd_en",     mon_e.id, int'(Rd_En),     int'(mon_e.re));
                chk("wr_addr",   mon_e.id, int'(Wr_Addr),   mon_e.wa);
                chk("rd_addr",   mon_e.id, int'(Rd_Addr),   mon_e.ra);
                chk("count",     mon_e.id, int'(Count),     mon_e.cnt);
                chk("full",      mon_e.id, int'(Full),      int'(mon_e.f));
                chk("empty",     mon_e.id, int'(Empty),     int'(mon_e.e));
                chk("overflow",  mon_e.id, int'(Overflow),  int'(mon_e.ov));
                chk("underflow", mon_e.id, int'(Underflow), int'(mon_e.un));
                diff = Wr_Addr - Rd_Addr;
                chk("invariant", mon_e.id, int'(Count), Full ? 8 : int'(diff));
            end
        end
    end

    initial begin
        Rst_n = 1'b0;
        Clear = 1'b0;
        Push  = 1'b0;
        Pop   = 1'b0;
        repeat (2) @(negedge Clk);

        // reset state
        cyc(0, 0,0,0, 0,0, 0,0,0, 0,1,0,0);
        // fill: eight pushes
        for (int k = 0; k < 8; k++)
            cyc(0, 1,0,0, 1,0, k,0,k, 0,(k == 0),0,0);
        // push while full, no pop
        cyc(0, 1,0,0, 0,0, 0,0,8, 1,0,0,0);
        cyc(0, 0,0,0, 0,0, 0,0,8, 1,0,1,0);
        // full with simultaneous push and pop
        for (int k = 0; k < 3; k++)
            cyc(0, 1,1,0, 1,1, k,k,8, 1,0,1,0);
        cyc(0, 0,0,0, 0,0, 3,3,8, 1,0,1,0);
        // pop-only out of full
        cyc(0, 0,1,0, 0,1, 3,3,8, 1,0,1,0);
        cyc(0, 0,0,0, 0,0, 3,4,7, 0,0,1,0);
        // flush
        cyc(0, 0,0,1, 0,0, 3,4,7, 0,0,1,0);
        cyc(0, 0,0,0, 0,0, 0,0,0, 0,1,0,0);
        // empty with simultaneous push and pop
        cyc(0, 1,1,0, 1,0, 0,0,0, 0,1,0,0);
        cyc(0, 0,0,0, 0,0, 1,0,1, 0,0,0,1);
        cyc(0, 0,1,0, 0,1, 1,0,1, 0,0,0,1);
        cyc(0, 0,0,0, 0,0, 1,1,0, 0,1,0,1);
        cyc(0, 0,1,0, 0,0, 1,1,0, 0,1,0,1);
        // clear, raise underflow, fill to five, then clear with a push
        cyc(0, 0,0,1, 0,0, 1,1,0, 0,1,0,1);
        cyc(0, 0,1,0, 0,0, 0,0,0, 0,1,0,0);
        for (int k = 0; k < 5; k++)
            cyc(0, 1,0,0, 1,0, k,0,k, 0,(k == 0),0,1);
        cyc(0, 1,0,1, 0,0, 5,0,5, 0,0,0,1);
        cyc(0, 0,0,0, 0,0, 0,0,0, 0,1,0,0);
        // fill to four, then asynchronous reset mid-stream
        for (int k = 0; k < 4; k++)
            cyc(0, 1,0,0, 1,0, k,0,k, 0,(k == 0),0,0);
        cyc(1, 0,0,0, 0,0, 0,0,0, 0,1,0,0);
        cyc(0, 0,0,0, 0,0, 0,0,0, 0,1,0,0);
        cyc(0, 1,0,0, 1,0, 0,0,0, 0,1,0,0);
        cyc(0, 0,0,0, 0,0, 1,0,1, 0,0,0,0);

        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", vec_id, exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
